sic_dispatch: RTL and testbench

- Responder for the SIC instruction-request handshake. Sits between the decoder output stream and NUM_SICS execution cores.
- Buffers decoded packets in a small FIFO and stamps each with a monotonically increasing issue_id.
- Delivers each packet as a one-cycle registered valid pulse to exactly one requesting SIC, chosen by round-robin.
- Drops all buffered packets on a redirect flush.

---
 rtl/sic_dispatch_pkg.sv | 24 ++
 rtl/sic_dispatch_if.sv | 38 +++
 rtl/sic_rr_arbiter.sv | 38 +++
 rtl/sic_dispatch.sv | 108 ++++++++++
 tb/tb_sic_dispatch.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sic_dispatch_pkg.sv
// Shared types for the SIC dispatch slice: the decoded packet format and
// pointer-width helpers used by the dispatcher and its arbiter.
package sic_dispatch_pkg;

   localparam int unsigned IdWidthMax = 8;
   localparam int unsigned PcWidth    = 32;
   localparam int unsigned InstrWidth = 32;

   typedef struct packed {
      logic                  valid;
      logic [IdWidthMax-1:0] issue_id;
      logic [PcWidth-1:0]    pc;
      logic [InstrWidth-1:0] instr;
   } sic_packet_t;

   // Index width for n entries; never below one bit so single-entry vectors stay legal.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned NumSicsDefault = 4;
   localparam int unsigned SicPtrWidth    = ptr_width(NumSicsDefault);

endpackage

// File: rtl/sic_dispatch_if.sv
// Decoder-to-dispatcher stream plus the per-SIC request/packet bundle.
// The dispatcher is the slave; the decoder/SIC environment is the master.
interface sic_dispatch_if
   import sic_dispatch_pkg::*;
#(
   parameter int unsigned NUM_SICS = 4,
   parameter int unsigned ID_WIDTH = 8
);

   sic_packet_t                 dec_pkt;
   logic                        dec_valid;
   logic                        dec_ready;
   logic                        flush;
   logic [NUM_SICS-1:0]         req_instr;
   sic_packet_t [NUM_SICS-1:0]  sic_pkt;
   logic [ID_WIDTH-1:0]         next_issue_id;

   modport slave (
      input  dec_pkt,
      input  dec_valid,
      input  flush,
      input  req_instr,
      output dec_ready,
      output sic_pkt,
      output next_issue_id
   );

   modport master (
      output dec_pkt,
      output dec_valid,
      output flush,
      output req_instr,
      input  dec_ready,
      input  sic_pkt,
      input  next_issue_id
   );

endinterface

// File: rtl/sic_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr_i,
// wrapping modulo NUM_SICS.
module sic_rr_arbiter
   import sic_dispatch_pkg::*;
#(
   parameter  int unsigned NUM_SICS = 4,
   localparam int unsigned PtrW     = ptr_width(NUM_SICS)
) (
   input  logic [NUM_SICS-1:0] eligible_i,
   input  logic [PtrW-1:0]     ptr_i,
   output logic [NUM_SICS-1:0] gnt_o,
   output logic [PtrW-1:0]     gnt_idx_o,
   output logic                any_gnt_o
);

   int unsigned     idx;
   logic [PtrW-1:0] sel;
   logic            found;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = 0;
      sel       = '0;
      for (int unsigned k = 0; k < NUM_SICS; k++) begin
         idx = (32'(ptr_i) + k) % NUM_SICS;
         sel = idx[PtrW-1:0];
         if (!found && eligible_i[sel]) begin
            found      = 1'b1;
            gnt_o[sel] = 1'b1;
            gnt_idx_o  = sel;
         end
      end
      any_gnt_o = found;
   end

endmodule

// File: rtl/sic_dispatch.sv
// Buffers decoded packets and hands each one, stamped with an issue id, to one
// requesting SIC as a single-cycle registered valid pulse.
module sic_dispatch
   import sic_dispatch_pkg::*;
#(
   parameter int unsigned NUM_SICS   = 4,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic           clk,
   input logic           rst_n,
   sic_dispatch_if.slave disp_io
);

   localparam int unsigned     PtrW    = ptr_width(NUM_SICS);
   localparam int unsigned     AddrW   = ptr_width(FIFO_DEPTH);
   localparam int unsigned     CntW    = $clog2(FIFO_DEPTH + 1);
   localparam logic [PtrW-1:0] LastSic = PtrW'(NUM_SICS - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

   sic_packet_t                mem_q [FIFO_DEPTH];
   logic [AddrW-1:0]           head_q, tail_q;
   logic [CntW-1:0]            count_q;
   logic [PtrW-1:0]            rr_ptr_q;
   logic [ID_WIDTH-1:0]        next_id_q;
   sic_packet_t [NUM_SICS-1:0] sic_pkt_q, sic_pkt_d;

   logic [NUM_SICS-1:0] eligible, gnt_onehot;
   logic [PtrW-1:0]     gnt_idx;
   logic                any_gnt, fifo_ready, fifo_empty, push, pop;

   assign fifo_ready = (count_q != FullCnt);
   assign fifo_empty = (count_q == '0);
   assign push       = disp_io.dec_valid && fifo_ready && !disp_io.flush;
   assign pop        = !fifo_empty && !disp_io.flush && any_gnt;

   // Eligibility looks only at registered outputs, so the SIC's combinational
   // req drop on valid can never loop back into the grant.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_SICS; i++) begin
         eligible[i] = disp_io.req_instr[i] && !sic_pkt_q[i].valid;
      end
   end

   sic_rr_arbiter #(
      .NUM_SICS (NUM_SICS)
   ) u_arb (
      .eligible_i (eligible),
      .ptr_i      (rr_ptr_q),
      .gnt_o      (gnt_onehot),
      .gnt_idx_o  (gnt_idx),
      .any_gnt_o  (any_gnt)
   );

   // Non-granted outputs fall back to all-zero, which makes every pulse one cycle wide.
   always_comb begin
      sic_pkt_d = '0;
      for (int i = 0; i < NUM_SICS; i++) begin
         if (pop && gnt_onehot[i]) begin
            sic_pkt_d[i]          = mem_q[head_q];
            sic_pkt_d[i].valid    = 1'b1;
            sic_pkt_d[i].issue_id = IdWidthMax'(next_id_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         rr_ptr_q  <= '0;
         next_id_q <= '0;
         sic_pkt_q <= '0;
      end else begin
         sic_pkt_q <= sic_pkt_d;
         if (disp_io.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (push) begin
               mem_q[tail_q] <= disp_io.dec_pkt;
               tail_q        <= tail_q + AddrW'(1);
            end
            if (pop) begin
               head_q    <= head_q + AddrW'(1);
               rr_ptr_q  <= (gnt_idx == LastSic) ? '0 : gnt_idx + PtrW'(1);
               next_id_q <= next_id_q + ID_WIDTH'(1);
            end
            case ({push, pop})
               2'b10:   count_q <= count_q + CntW'(1);
               2'b01:   count_q <= count_q - CntW'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   assign disp_io.dec_ready     = fifo_ready;
   assign disp_io.sic_pkt       = sic_pkt_q;
   assign disp_io.next_issue_id = next_id_q;

endmodule

// File: tb/tb_sic_dispatch.sv
// Directed bench for sic_dispatch: delivery, round-robin, backpressure, flush
// and issue-id wrap, each against hand-computed expectations.
module tb_sic_dispatch;
   import sic_dispatch_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   sic_dispatch_if #(.NUM_SICS(4), .ID_WIDTH(8)) disp ();
   sic_dispatch_if #(.NUM_SICS(4), .ID_WIDTH(2)) disp_w ();

   sic_dispatch #(
      .NUM_SICS   (4),
      .ID_WIDTH   (8),
      .FIFO_DEPTH (4)
   ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .disp_io (disp)
   );

   sic_dispatch #(
      .NUM_SICS   (4),
      .ID_WIDTH   (2),
      .FIFO_DEPTH (4)
   ) u_dut_w (
      .clk     (clk),
      .rst_n   (rst_n),
      .disp_io (disp_w)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic sic_packet_t make_pkt(input logic [31:0] pc);
      sic_packet_t p;
      p          = '0;
      p.pc       = pc;
      p.instr    = pc ^ 32'hA5A5_0000;
      p.issue_id = 8'hEE;  // must be ignored by the DUT
      return p;
   endfunction

   function automatic sic_packet_t exp_pkt(input logic [31:0] pc, input logic [7:0] id);
      sic_packet_t p;
      p          = '0;
      p.valid    = 1'b1;
      p.issue_id = id;
      p.pc       = pc;
      p.instr    = pc ^ 32'hA5A5_0000;
      return p;
   endfunction

   function automatic logic [3:0] vvec();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = disp.sic_pkt[i].valid;
      return v;
   endfunction

   task automatic do_reset();
      rst_n            = 1'b0;
      disp.dec_pkt     = '0;
      disp.dec_valid   = 1'b0;
      disp.flush       = 1'b0;
      disp.req_instr   = '0;
      disp_w.dec_pkt   = '0;
      disp_w.dec_valid = 1'b0;
      disp_w.flush     = 1'b0;
      disp_w.req_instr = '0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      step();
      do_reset();

      // Reset state
      check_eq("rst_ready", 128'(disp.dec_ready), 128'd1);
      check_eq("rst_next_id", 128'(disp.next_issue_id), 128'd0);
      check_eq("rst_next_id_w", 128'(disp_w.next_issue_id), 128'd0);
      for (int j = 0; j < 4; j++) check_eq("rst_pkt", 128'(disp.sic_pkt[j]), 128'd0);

      // Basic delivery: accepted at edge 0, visible after edge 1
      disp.req_instr = 4'b0001;
      disp.dec_pkt   = make_pkt(32'h0040_0000);
      disp.dec_valid = 1'b1;
      step();
      disp.dec_valid = 1'b0;
      check_eq("basic_c1_none", 128'(vvec()), 128'd0);
      step();
      check_eq("basic_pkt0", 128'(disp.sic_pkt[0]), 128'(exp_pkt(32'h0040_0000, 8'd0)));
      for (int j = 1; j < 4; j++) check_eq("basic_other", 128'(disp.sic_pkt[j]), 128'd0);
      check_eq("basic_next_id", 128'(disp.next_issue_id), 128'd1);
      step();
      check_eq("basic_pulse_end", 128'(vvec()), 128'd0);

      // Round-robin with all SICs requesting
      do_reset();
      disp.req_instr = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         disp.dec_pkt   = make_pkt(32'h1000 + 32'(k));
         disp.dec_valid = 1'b1;
         step();
         check_eq("rr_ready", 128'(disp.dec_ready), 128'd1);
         if (k >= 1) begin
            check_eq("rr_vec", 128'(vvec()), 128'(4'b0001 << ((k - 1) % 4)));
            check_eq("rr_pkt", 128'(disp.sic_pkt[(k - 1) % 4]),
                     128'(exp_pkt(32'h1000 + 32'(k - 1), 8'(k - 1))));
         end
      end
      disp.dec_valid = 1'b0;
      step();
      check_eq("rr_vec_last", 128'(vvec()), 128'(4'b0010));
      check_eq("rr_pkt_last", 128'(disp.sic_pkt[1]), 128'(exp_pkt(32'h1005, 8'd5)));
      step();
      check_eq("rr_idle", 128'(vvec()), 128'd0);

      // Backpressure: fill with nobody requesting, then drain to SIC 2
      do_reset();
      for (int k = 0; k < 4; k++) begin
         disp.dec_pkt   = make_pkt(32'h2000 + 32'(k));
         disp.dec_valid = 1'b1;
         step();
      end
      check_eq("bp_full", 128'(disp.dec_ready), 128'd0);
      disp.dec_pkt = make_pkt(32'h2004);
      step();
      step();
      check_eq("bp_held", 128'(disp.dec_ready), 128'd0);
      check_eq("bp_no_req", 128'(vvec()), 128'd0);
      disp.req_instr = 4'b0100;
      step();
      check_eq("bp_first", 128'(disp.sic_pkt[2]), 128'(exp_pkt(32'h2000, 8'd0)));
      check_eq("bp_ready_after_pop", 128'(disp.dec_ready), 128'd1);
      step();
      disp.dec_valid = 1'b0;
      check_eq("bp_gap", 128'(vvec()), 128'd0);
      check_eq("bp_refull", 128'(disp.dec_ready), 128'd0);
      for (int j = 1; j < 5; j++) begin
         step();
         check_eq("bp_vec", 128'(vvec()), 128'(4'b0100));
         check_eq("bp_pkt", 128'(disp.sic_pkt[2]), 128'(exp_pkt(32'h2000 + 32'(j), 8'(j))));
         step();
         check_eq("bp_gap", 128'(vvec()), 128'd0);
      end

      // Flush drops buffered packets but keeps the id counter
      do_reset();
      disp.req_instr = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         disp.dec_pkt   = make_pkt(32'h5000 + 32'(k));
         disp.dec_valid = 1'b1;
         step();
      end
      disp.dec_valid = 1'b0;
      step();
      step();
      check_eq("fl_pre_id", 128'(disp.next_issue_id), 128'd3);
      disp.req_instr = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         disp.dec_pkt   = make_pkt(32'h6000 + 32'(k));
         disp.dec_valid = 1'b1;
         step();
      end
      disp.dec_valid = 1'b0;
      check_eq("fl_full", 128'(disp.dec_ready), 128'd0);
      disp.flush = 1'b1;
      step();
      disp.flush = 1'b0;
      check_eq("fl_ready", 128'(disp.dec_ready), 128'd1);
      check_eq("fl_id_kept", 128'(disp.next_issue_id), 128'd3);
      disp.req_instr = 4'b0001;
      step();
      check_eq("fl_empty1", 128'(vvec()), 128'd0);
      step();
      check_eq("fl_empty2", 128'(vvec()), 128'd0);
      disp.dec_pkt   = make_pkt(32'h7000);
      disp.dec_valid = 1'b1;
      step();
      disp.dec_valid = 1'b0;
      step();
      check_eq("fl_after", 128'(disp.sic_pkt[0]), 128'(exp_pkt(32'h7000, 8'd3)));

      // Flush in the same cycle a SIC is eligible
      do_reset();
      disp.req_instr = 4'b0001;
      disp.dec_pkt   = make_pkt(32'h3000);
      disp.dec_valid = 1'b1;
      step();
      disp.dec_pkt = make_pkt(32'h3001);
      step();
      disp.dec_valid = 1'b0;
      disp.req_instr = 4'b0011;
      disp.flush     = 1'b1;
      #1;
      check_eq("fdg_visible", 128'(disp.sic_pkt[0]), 128'(exp_pkt(32'h3000, 8'd0)));
      step();
      disp.flush = 1'b0;
      check_eq("fdg_no_valid", 128'(vvec()), 128'd0);
      check_eq("fdg_id", 128'(disp.next_issue_id), 128'd1);
      step();
      check_eq("fdg_dropped", 128'(vvec()), 128'd0);

      // Issue-id wrap with a 2-bit counter
      do_reset();
      disp_w.req_instr = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         disp_w.dec_pkt   = make_pkt(32'h8000 + 32'(k));
         disp_w.dec_valid = 1'b1;
         step();
         if (k >= 1) begin
            check_eq("wrap_pkt", 128'(disp_w.sic_pkt[(k - 1) % 4]),
                     128'(exp_pkt(32'h8000 + 32'(k - 1), 8'((k - 1) % 4))));
         end
      end
      disp_w.dec_valid = 1'b0;
      step();
      check_eq("wrap_pkt5", 128'(disp_w.sic_pkt[0]), 128'(exp_pkt(32'h8004, 8'd0)));
      check_eq("wrap_next_id", 128'(disp_w.next_issue_id), 128'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
